// File: rtl/mmio_pwm_bank_pkg.sv
// mmio_pwm_pkg: register offsets, CTRL field positions and per-channel config type for mmio_pwm_bank
package mmio_pwm_pkg;
  localparam int CTRL = 'h00;
  localparam int LEDS = 'h04;
  localparam int STATUS = 'h08;
  localparam int CH_BASE = 'h10;
  localparam int CH_STRIDE = 8;
  localparam int CTRL_EN = 0;
  localparam int CTRL_CENTER = 8;
  localparam int CFG_W = 32;
  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] duty;
    logic             en;
    logic             center;
  } pwm_cfg_t;
endpackage

// File: rtl/mmio_pwm_bank_if.sv
// mmio_pwm_bank_if: CPU data-bus slice (sel, we, addr, wdata -> rdata) with master/slave modports
interface mmio_pwm_bank_if #(
  parameter int ADDR_W = 8
);
  logic              sel;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  modport master(output sel, we, addr, wdata, input rdata);
  modport slave(input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_pwm_bank_channel.sv
// pwm_channel: one PWM channel (cnt, dir, active period/duty, output flop); ports clk, reset (async low), cfg in, pwm/wrap out
module pwm_channel
  import mmio_pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  pwm_cfg_t cfg,
  output logic     pwm,
  output logic     wrap
);
  logic [CNT_W-1:0] cnt, cnt_n, period_a, duty_a;
  logic dir, dir_n, up, rising, unused;
  assign up = !dir || cnt == '0;
  assign rising = up && cnt < period_a;
  assign unused = ^{cfg.period, cfg.duty};
  assign wrap = cfg.en && cnt_n == '0;
  always_comb begin
    cnt_n = '0;
    dir_n = 1'b0;
    if (cfg.en && !cfg.center) cnt_n = cnt >= period_a ? '0 : cnt + CNT_W'(1);
    if (cfg.en && cfg.center) begin
      cnt_n = period_a == '0 ? '0 : rising ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
      dir_n = cnt_n != '0 && !rising;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      dir <= 1'b0;
      period_a <= '0;
      duty_a <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= cnt_n;
      dir <= dir_n;
      if (!cfg.en || wrap) begin
        period_a <= cfg.period[CNT_W-1:0];
        duty_a <= cfg.duty[CNT_W-1:0];
      end
      pwm <= cfg.en && cnt < duty_a;
    end
endmodule

// File: rtl/mmio_pwm_bank.sv
// mmio_pwm_bank: MMIO PWM/LED bank; ports clk, reset (async low), bus (slave: sel/we/addr/wdata/rdata), leds, pwm_out
module mmio_pwm_bank
  import mmio_pwm_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CNT_W = 16,
  parameter int LED_W = 4,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  mmio_pwm_bank_if.slave     bus,
  output logic [LED_W-1:0]   leds,
  output logic [NCH-1:0]     pwm_out
);
  logic [ADDR_W-1:0] wa, ch_off;
  logic [2:0] ch;
  logic is_ch, wr, unused;
  logic [NCH-1:0] en, center, status, wrap;
  logic [NCH-1:0][CNT_W-1:0] period_stg, duty_stg;
  assign wa = {bus.addr[ADDR_W-1:2], 2'b00};
  assign ch_off = wa - ADDR_W'(CH_BASE);
  assign ch = ch_off[5:3];
  assign is_ch = wa >= ADDR_W'(CH_BASE) && ch_off < ADDR_W'(CH_STRIDE * NCH);
  assign wr = bus.sel && bus.we;
  assign unused = ^{bus.wdata, bus.addr[1:0], ch_off};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      en <= '0;
      center <= '0;
      leds <= '0;
      status <= '0;
      period_stg <= '0;
      duty_stg <= '0;
    end else begin
      if (wr && wa == ADDR_W'(CTRL)) begin
        en <= bus.wdata[CTRL_EN +: NCH];
        center <= bus.wdata[CTRL_CENTER +: NCH];
      end
      if (wr && wa == ADDR_W'(LEDS)) leds <= bus.wdata[LED_W-1:0];
      status <= (wr && wa == ADDR_W'(STATUS) ? status & ~bus.wdata[NCH-1:0] : status) | wrap;
      for (int i = 0; i < NCH; i++)
        if (wr && is_ch && ch == 3'(i)) begin
          if (ch_off[2]) duty_stg[i] <= bus.wdata[CNT_W-1:0];
          else period_stg[i] <= bus.wdata[CNT_W-1:0];
        end
    end
  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NCH; i++)
      if (is_ch && ch == 3'(i)) bus.rdata = 32'(ch_off[2] ? duty_stg[i] : period_stg[i]);
    if (wa == ADDR_W'(CTRL)) bus.rdata = (32'(en) << CTRL_EN) | (32'(center) << CTRL_CENTER);
    if (wa == ADDR_W'(LEDS)) bus.rdata = 32'(leds);
    if (wa == ADDR_W'(STATUS)) bus.rdata = 32'(status);
    if (!bus.sel) bus.rdata = '0;
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_cfg_t cfg;
    assign cfg = '{period: CFG_W'(period_stg[i]), duty: CFG_W'(duty_stg[i]), en: en[i], center: center[i]};
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .reset(reset),
      .cfg(cfg),
      .pwm(pwm_out[i]),
      .wrap(wrap[i])
    );
  end
endmodule

// File: tb/tb_mmio_pwm_bank.sv
// tb_mmio_pwm_bank: directed self-checking bench for mmio_pwm_bank
module tb_mmio_pwm_bank;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] leds;
  logic [3:0] pwm_out;
  int n_chk = 0;
  int n_fail = 0;
  int w;
  logic [31:0] d, v, e, s, se;
  logic [7:0] ra [6] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h2C};
  logic [7:0] oa [12] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34};
  logic [31:0] od [12] = '{32'h1, 32'hA, 32'd9, 32'd3, 32'd9, 32'd20, 32'd4, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
  mmio_pwm_bank_if #(.ADDR_W(8)) bus ();
  mmio_pwm_bank #(.NCH(4), .CNT_W(16), .LED_W(4), .ADDR_W(8)) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .leds(leds),
    .pwm_out(pwm_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] dat);
    bus.sel = 1'b1;
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdata = dat;
    @(negedge clk);
    bus.sel = 1'b0;
    bus.we = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, output logic [31:0] dat);
    bus.sel = 1'b1;
    bus.we = 1'b0;
    bus.addr = a;
    #1;
    dat = bus.rdata;
    bus.sel = 1'b0;
  endtask
  function automatic logic [31:0] cexp(input int k);
    int m;
    m = k % 8;
    return 32'(m <= 4 ? m : 8 - m);
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.sel = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.sel = 1'($urandom);
      bus.we = 1'($urandom);
      bus.addr = 8'($urandom);
      bus.wdata = $urandom;
    end
    @(negedge clk);
    bus.sel = 1'b0;
    bus.we = 1'b0;
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_leds", 32'(leds), 0);
    for (int i = 0; i < 6; i++) begin
      rd(ra[i], d);
      check("rst_read", d, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr(8'h04, 32'hFFFF_FFFA);
    check("leds_out", 32'(leds), 32'hA);
    rd(8'h04, d);
    check("leds_read", d, 32'hA);
    wr(8'h08, 32'hF);
    rd(8'h08, d);
    check("status_idle", d, 0);
    wr(8'h10, 9);
    wr(8'h14, 3);
    wr(8'h00, 1);
    v = '0; e = '0; s = '0; se = '0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 21) wr(8'h08, 1);
      else @(negedge clk);
      v[k-1] = pwm_out[0];
      rd(8'h08, d);
      s[k-1] = d[0];
      e[k-1] = ((k - 1) % 10) < 3;
      se[k-1] = (k >= 10 && k <= 20) || k == 30;
    end
    check("edge_pwm", v, e);
    check("edge_status", s, se);
    wr(8'h18, 9);
    wr(8'h1C, 3);
    wr(8'h00, 2);
    v = '0; e = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 6) wr(8'h1C, 7);
      else @(negedge clk);
      v[k-1] = pwm_out[1];
      e[k-1] = k <= 3 || (k >= 11 && k <= 17);
    end
    check("dbuf_pwm", v, e);
    rd(8'h1C, d);
    check("dbuf_read", d, 7);
    wr(8'h1C, 0);
    repeat (12) @(negedge clk);
    v = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      v[k] = pwm_out[1];
    end
    check("duty0_low", v, 0);
    wr(8'h1C, 20);
    repeat (12) @(negedge clk);
    v = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      v[k] = pwm_out[1];
    end
    check("duty20_high", v, 32'h3FF);
    wr(8'h20, 4);
    wr(8'h24, 2);
    wr(8'h00, 32'h0404);
    check("ctr_cnt0", 32'(u_dut.g_ch[2].u_ch.cnt), 0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("ctr_cnt", 32'(u_dut.g_ch[2].u_ch.cnt), cexp(k));
      check("ctr_pwm", 32'(pwm_out[2]), 32'(cexp(k - 1) < 2));
    end
    repeat (8) @(negedge clk);
    wr(8'h00, 0);
    @(negedge clk);
    check("dis_pwm", 32'(pwm_out[2]), 0);
    check("dis_cnt", 32'(u_dut.g_ch[2].u_ch.cnt), 0);
    wr(8'h08, 32'hF);
    rd(8'h08, d);
    check("status_clr_all", d, 0);
    wr(8'h00, 1);
    repeat (9) @(negedge clk);
    rd(8'h08, d);
    check("pre_wrap_status", d, 0);
    wr(8'h08, 1);
    rd(8'h08, d);
    check("set_wins_clear", d, 1);
    rd(8'h0C, d);
    check("unmapped_read", d, 0);
    rd(8'h30, d);
    check("oor_read", d, 0);
    wr(8'h30, 32'h1234);
    wr(8'h34, 32'h5678);
    for (int i = 0; i < 12; i++) begin
      rd(oa[i], d);
      check("oor_nochange", d, od[i]);
    end
    w = 0;
    while (!pwm_out[0] && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("pre_rst_high", 32'(pwm_out[0]), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm_out), 0);
    check("arst_leds", 32'(leds), 0);
    check("arst_cnt", 32'(u_dut.g_ch[0].u_ch.cnt), 0);
    rd(8'h00, d);
    check("arst_ctrl", d, 0);
    rd(8'h10, d);
    check("arst_period", d, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_pwm", 32'(pwm_out), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
